tuned_mixer_dac: RTL

TUNED_MIXER_DAC -- requirements
Module: tuned_mixer_dac

---
 rtl/tuned_mixer_pkg.sv | 59 +++++
 rtl/tuned_mixer_dac_nco.sv | 47 ++++
 rtl/tuned_mixer_dac.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tuned_mixer_pkg.sv
// Shared types, constants and elaboration-time helpers for the tuned mixer DAC.
package tuned_mixer_pkg;

    localparam logic TW_SEL_LO = 1'b0;
    localparam logic TW_SEL_RF = 1'b1;

    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_t;

    // Fixed-point format used while building the trig table
    localparam int unsigned FRAC_W = 30;
    localparam longint      PI_Q   = 64'sd3373259426;

    // Width of one signed AMP_W x AMP_W product
    function automatic int unsigned product_width(input int unsigned amp_w);
        return 2 * amp_w;
    endfunction

    // Width of a sum/difference of two products
    function automatic int unsigned sum_width(input int unsigned amp_w);
        return 2 * amp_w + 1;
    endfunction

    // round((2^(amp_w-1)-1) * cos|sin(2*pi*k/2^aw)), integer-only so it folds at elaboration; aw >= 2
    function automatic int lut_value(input int unsigned k, input int unsigned aw,
                                     input int unsigned amp_w, input bit want_sin);
        longint one, n, quarter, quad, r, x, x2, term, c, s, v, amp, mag;
        one     = 64'sd1 <<< FRAC_W;
        n       = 64'sd1 <<< aw;
        quarter = n / 64'sd4;
        quad    = longint'(k) / quarter;
        r       = longint'(k) % quarter;
        x       = (64'sd2 * PI_Q * r) / n;
        x2      = (x * x) >>> FRAC_W;
        c       = one;
        term    = one;
        for (int i = 1; i <= 8; i++) begin
            term = -((term * x2) >>> FRAC_W) / longint'((2 * i - 1) * (2 * i));
            c    = c + term;
        end
        s    = x;
        term = x;
        for (int i = 1; i <= 8; i++) begin
            term = -((term * x2) >>> FRAC_W) / longint'((2 * i) * (2 * i + 1));
            s    = s + term;
        end
        if (quad == 64'sd0)      v = want_sin ? s  : c;
        else if (quad == 64'sd1) v = want_sin ? c  : -s;
        else if (quad == 64'sd2) v = want_sin ? -s : -c;
        else                     v = want_sin ? -c : s;
        amp = (64'sd1 <<< (amp_w - 1)) - 64'sd1;
        mag = (v < 0) ? -v : v;
        mag = (mag * amp + (one >>> 1)) >>> FRAC_W;
        return (v < 0) ? -32'(mag) : 32'(mag);
    endfunction

endpackage

// File: rtl/tuned_mixer_dac_nco.sv
// nco_core: phase accumulator plus registered cos/sin table lookup.
import tuned_mixer_pkg::*;

module nco_core #(
    parameter int unsigned PHASE_W = 8,
    parameter int unsigned LUT_AW  = 6,
    parameter int unsigned AMP_W   = 5
) (
    input  logic                     pll_clock,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic [PHASE_W-1:0]       tw,
    output logic signed [AMP_W-1:0]  cos_val,
    output logic signed [AMP_W-1:0]  sin_val
);

    localparam int unsigned LUT_N = 1 << LUT_AW;

    logic [PHASE_W-1:0]      phase;
    logic [LUT_AW-1:0]       addr_c;
    logic signed [AMP_W-1:0] cos_rom [LUT_N];
    logic signed [AMP_W-1:0] sin_rom [LUT_N];

    // Constant tables folded at elaboration
    for (genvar g = 0; g < LUT_N; g++) begin : g_rom
        localparam int COS_V = lut_value(32'(g), LUT_AW, AMP_W, 1'b0);
        localparam int SIN_V = lut_value(32'(g), LUT_AW, AMP_W, 1'b1);
        assign cos_rom[g] = AMP_W'(COS_V);
        assign sin_rom[g] = AMP_W'(SIN_V);
    end

    assign addr_c = phase[PHASE_W-1 -: LUT_AW];

    // Accumulate phase modulo 2^PHASE_W and register the sample for the current phase
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            phase   <= '0;
            cos_val <= '0;
            sin_val <= '0;
        end else if (clk_en) begin
            phase   <= phase + tw;
            cos_val <= cos_rom[addr_c];
            sin_val <= sin_rom[addr_c];
        end
    end

endmodule

// File: rtl/tuned_mixer_dac.sv
// tuned_mixer_dac: two NCOs, complex mixer and offset-binary DAC output stage.
// Define MIXER_ROUND_EN for round-half-up with positive saturation at the output; default truncates.
import tuned_mixer_pkg::*;

module tuned_mixer_dac #(
    parameter int unsigned PHASE_W    = 8,
    parameter int unsigned LUT_AW     = 6,
    parameter int unsigned AMP_W      = 5,
    parameter int unsigned DAC_W      = 6,
    parameter int unsigned LO_TW_INIT = 3,
    parameter int unsigned RF_TW_INIT = 13
) (
    input  logic               pll_clock,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               tw_valid,
    output logic               tw_ready,
    input  logic               tw_sel,
    input  logic [PHASE_W-1:0] tw_data,
    output logic [DAC_W-1:0]   dac_zero,
    output logic [DAC_W-1:0]   dac_one,
    output logic               out_valid
);

    localparam int unsigned PROD_W = product_width(AMP_W);
    localparam int unsigned SUM_W  = sum_width(AMP_W);
    localparam int unsigned DROP_W = SUM_W - DAC_W;
    localparam logic [DAC_W-1:0] MSB_MASK = DAC_W'(1) << (DAC_W - 1);

    hs_state_t               state_q, state_d;
    logic                    accept_c, apply_c;
    logic                    shadow_sel;
    logic [PHASE_W-1:0]      shadow_data;
    logic [PHASE_W-1:0]      lo_tw, rf_tw;
    logic signed [AMP_W-1:0] lo_cos, lo_sin, rf_cos, rf_sin;
    logic signed [PROD_W-1:0] p_ii_c, p_qq_c, p_iq_c, p_qi_c;
    logic signed [SUM_W-1:0] mix_i, mix_q;
    logic [DAC_W-1:0]        code_i_c, code_q_c;
    logic [1:0]              valid_cnt;
    logic                    unused_c;

    assign tw_ready = (state_q == HS_IDLE) && !reset;
    assign accept_c = tw_valid && tw_ready;

    // Handshake state register
    always_ff @(posedge pll_clock) begin
        if (reset) state_q <= HS_IDLE;
        else       state_q <= state_d;
    end

    // Handshake next state: a pending word is applied on the next enabled cycle
    always_comb begin
        state_d = state_q;
        apply_c = 1'b0;
        case (state_q)
            HS_IDLE:    if (accept_c) state_d = HS_PENDING;
            HS_PENDING: if (clk_en) begin
                state_d = HS_IDLE;
                apply_c = 1'b1;
            end
            default:    state_d = HS_IDLE;
        endcase
    end

    // Shadow capture and tuning-word registers
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            shadow_sel  <= TW_SEL_LO;
            shadow_data <= '0;
            lo_tw       <= PHASE_W'(LO_TW_INIT);
            rf_tw       <= PHASE_W'(RF_TW_INIT);
        end else begin
            if (accept_c) begin
                shadow_sel  <= tw_sel;
                shadow_data <= tw_data;
            end
            if (apply_c) begin
                if (shadow_sel == TW_SEL_RF) rf_tw <= shadow_data;
                else                         lo_tw <= shadow_data;
            end
        end
    end

    nco_core #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W)) u_lo (
        .pll_clock (pll_clock),
        .reset     (reset),
        .clk_en    (clk_en),
        .tw        (lo_tw),
        .cos_val   (lo_cos),
        .sin_val   (lo_sin)
    );

    nco_core #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W)) u_rf (
        .pll_clock (pll_clock),
        .reset     (reset),
        .clk_en    (clk_en),
        .tw        (rf_tw),
        .cos_val   (rf_cos),
        .sin_val   (rf_sin)
    );

    assign p_ii_c = PROD_W'(rf_cos) * PROD_W'(lo_cos);
    assign p_qq_c = PROD_W'(rf_sin) * PROD_W'(lo_sin);
    assign p_iq_c = PROD_W'(rf_cos) * PROD_W'(lo_sin);
    assign p_qi_c = PROD_W'(rf_sin) * PROD_W'(lo_cos);

    // Full-precision complex multiply
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            mix_i <= '0;
            mix_q <= '0;
        end else if (clk_en) begin
            mix_i <= SUM_W'(p_ii_c) - SUM_W'(p_qq_c);
            mix_q <= SUM_W'(p_iq_c) + SUM_W'(p_qi_c);
        end
    end

`ifdef MIXER_ROUND_EN
    localparam int unsigned RND_W = SUM_W + 1;
    localparam logic [RND_W-1:0] RND_ADD = (RND_W'(1) << DROP_W) >> 1;
    logic [RND_W-1:0] rnd_i_c, rnd_q_c;

    assign rnd_i_c = RND_W'(mix_i) + RND_ADD;
    assign rnd_q_c = RND_W'(mix_q) + RND_ADD;

    // Round half up; a carry into the sign bit clamps to the largest positive code
    always_comb begin
        code_i_c = (rnd_i_c[RND_W-1] != rnd_i_c[RND_W-2]) ? ~MSB_MASK : rnd_i_c[RND_W-2 -: DAC_W];
        code_q_c = (rnd_q_c[RND_W-1] != rnd_q_c[RND_W-2]) ? ~MSB_MASK : rnd_q_c[RND_W-2 -: DAC_W];
    end

    assign unused_c = ^{rnd_i_c, rnd_q_c, mix_i, mix_q};
`else
    assign code_i_c = mix_i[SUM_W-1 -: DAC_W];
    assign code_q_c = mix_q[SUM_W-1 -: DAC_W];
    assign unused_c = ^{mix_i, mix_q};
`endif

    // Two's complement to offset binary by flipping the sign bit
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            dac_zero <= MSB_MASK;
            dac_one  <= MSB_MASK;
        end else if (clk_en) begin
            dac_zero <= code_i_c ^ MSB_MASK;
            dac_one  <= code_q_c ^ MSB_MASK;
        end
    end

    // out_valid rises on the 4th enabled cycle after reset and stays high
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            valid_cnt <= '0;
            out_valid <= 1'b0;
        end else if (clk_en && !out_valid) begin
            if (valid_cnt == 2'd3) out_valid <= 1'b1;
            else                   valid_cnt <= valid_cnt + 2'd1;
        end
    end

endmodule
